// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button edge decode, IDLE/RUN/PAUSE/LAP control and an
// MM:SS.cc BCD time counter advanced by a 100 Hz tick. Produces a registered
// packed-BCD display word plus status flags for the seven-segment driver.
module stopwatch_ctrl #(
  parameter int unsigned MAX_MIN    = 59,   // last minute value before saturation, 0..59
  parameter bit          AUTO_RANGE = 1'b1  // 1: SS.cc while minutes are zero
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        btn_start,
  input  logic        btn_lap,
  input  logic        btn_clear,
  output logic [15:0] value,
  output logic        disp_mode,
  output logic        running,
  output logic        lap_active,
  output logic        overflow
);

  localparam logic [3:0] MaxM1 = 4'(MAX_MIN / 10);
  localparam logic [3:0] MaxM0 = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StLap} state_e;

  typedef struct packed {
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
    logic [3:0] c1;
    logic [3:0] c0;
  } bcd_time_t;

  state_e    state_q, state_d;
  bcd_time_t live_q, live_d, live_inc;
  bcd_time_t snap_q, snap_d;
  bcd_time_t src;
  logic      ovf_q, ovf_d;

  logic start_q, lap_q, clear_q;
  logic raw_start, raw_lap, raw_clear;
  logic ev_start, ev_lap, ev_clear;
  logic count_en, at_max, sat;

  logic [15:0] value_d;
  logic        disp_mode_d;

  // Rising-edge detection; a held level yields a single event.
  assign raw_start = btn_start & ~start_q;
  assign raw_lap   = btn_lap & ~lap_q;
  assign raw_clear = btn_clear & ~clear_q;

  // Priority clear > start > lap: any higher event drops the lower ones,
  // even in states where the higher event itself has no effect.
  assign ev_clear = raw_clear;
  assign ev_start = raw_start & ~raw_clear;
  assign ev_lap   = raw_lap & ~raw_start & ~raw_clear;

  assign at_max = (live_q.m1 == MaxM1) && (live_q.m0 == MaxM0) &&
                  (live_q.s1 == 4'd5) && (live_q.s0 == 4'd9) &&
                  (live_q.c1 == 4'd9) && (live_q.c0 == 4'd9);

  // Counting uses the state before this cycle's events take effect.
  assign count_en = tick & ((state_q == StRun) | (state_q == StLap));
  assign sat      = count_en & at_max;

  // Previous button levels for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      lap_q   <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      start_q <= btn_start;
      lap_q   <= btn_lap;
      clear_q <= btn_clear;
    end
  end

  // BCD +1 centisecond with carries cc -> SS -> MM; saturation handled by the caller.
  always_comb begin
    live_inc = live_q;
    if (live_q.c0 != 4'd9) begin
      live_inc.c0 = live_q.c0 + 4'd1;
    end else begin
      live_inc.c0 = 4'd0;
      if (live_q.c1 != 4'd9) begin
        live_inc.c1 = live_q.c1 + 4'd1;
      end else begin
        live_inc.c1 = 4'd0;
        if (live_q.s0 != 4'd9) begin
          live_inc.s0 = live_q.s0 + 4'd1;
        end else begin
          live_inc.s0 = 4'd0;
          if (live_q.s1 != 4'd5) begin
            live_inc.s1 = live_q.s1 + 4'd1;
          end else begin
            live_inc.s1 = 4'd0;
            if (live_q.m0 != 4'd9) begin
              live_inc.m0 = live_q.m0 + 4'd1;
            end else begin
              live_inc.m0 = 4'd0;
              live_inc.m1 = live_q.m1 + 4'd1;
            end
          end
        end
      end
    end
  end

  // Next state, counter, snapshot and sticky overflow.
  always_comb begin
    state_d = state_q;
    live_d  = live_q;
    snap_d  = snap_q;
    ovf_d   = ovf_q;

    if (count_en && !at_max) begin
      live_d = live_inc;
    end

    case (state_q)
      StIdle: begin
        if (ev_start) state_d = StRun;
      end
      StRun: begin
        if (ev_start) begin
          state_d = StPause;
        end else if (ev_lap) begin
          state_d = StLap;
          snap_d  = live_q;  // value before this cycle's tick
        end
      end
      StLap: begin
        if (ev_lap) begin
          state_d = StRun;
        end else if (ev_start) begin
          state_d = StPause;
        end
      end
      StPause: begin
        if (ev_clear) begin
          state_d = StIdle;
          live_d  = '0;
          snap_d  = '0;
          ovf_d   = 1'b0;
        end else if (ev_start) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase

    // Saturation overrides any event: hold the count and fall back to PAUSE,
    // which also drops a LAP snapshot from the display.
    if (sat) begin
      ovf_d   = 1'b1;
      state_d = StPause;
    end
  end

  // Control state and time registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      live_q  <= '0;
      snap_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= live_d;
      snap_q  <= snap_d;
      ovf_q   <= ovf_d;
    end
  end

  // Display word selection: snapshot in LAP, auto-ranging on zero minutes.
  always_comb begin
    src         = (state_q == StLap) ? snap_q : live_q;
    value_d     = {src.m1, src.m0, src.s1, src.s0};
    disp_mode_d = 1'b1;
    if (AUTO_RANGE && (src.m1 == 4'd0) && (src.m0 == 4'd0)) begin
      value_d     = {src.s1, src.s0, src.c1, src.c0};
      disp_mode_d = 1'b0;
    end
  end

  // Registered outputs, one clock behind the state/counter update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value      <= 16'h0000;
      disp_mode  <= 1'b0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      value      <= value_d;
      disp_mode  <= disp_mode_d;
      running    <= (state_q == StRun) || (state_q == StLap);
      lap_active <= (state_q == StLap);
      overflow   <= ovf_q;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: two instances (default and MAX_MIN=0/AUTO_RANGE=0)
// share stimulus; a centisecond-integer reference model feeds per-DUT queues
// that a monitor drains every clock, plus directed spot checks.
module tb_stopwatch_ctrl;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_LAP = 3;

  typedef struct {
    int st;
    int live;  // centiseconds
    int snap;
    bit ovf;
    bit ps, pl, pc;
  } mdl_t;

  typedef struct {
    logic [15:0] value;
    logic        dm, run, lap, ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0, btn_start = 1'b0, btn_lap = 1'b0, btn_clear = 1'b0;

  logic [15:0] value_a, value_b;
  logic dm_a, run_a, lap_a, ovf_a;
  logic dm_b, run_b, lap_b, ovf_b;

  int n_chk = 0;
  int n_fail = 0;

  mdl_t ma, mb;
  exp_t qa[$];
  exp_t qb[$];
  bit cs, cl, cc;  // current button levels

  always #5 clk = ~clk;

  stopwatch_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .value(value_a), .disp_mode(dm_a), .running(run_a), .lap_active(lap_a), .overflow(ovf_a)
  );

  stopwatch_ctrl #(.MAX_MIN(0), .AUTO_RANGE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .value(value_b), .disp_mode(dm_b), .running(run_b), .lap_active(lap_b), .overflow(ovf_b)
  );

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.st = S_IDLE; m.live = 0; m.snap = 0; m.ovf = 1'b0;
    m.ps = 1'b0; m.pl = 1'b0; m.pc = 1'b0;
    return m;
  endfunction

  // One clock of the stopwatch rules applied to time held as an integer.
  function automatic mdl_t step(mdl_t m, int max_min, bit s, bit l, bit c, bit t);
    mdl_t n = m;
    bit ec, es, el, cnt, sat;
    int limit;
    ec = c && !m.pc;
    es = s && !m.ps && !ec;
    el = l && !m.pl && !ec && !(s && !m.ps);
    limit = max_min * 6000 + 5999;
    cnt = t && (m.st == S_RUN || m.st == S_LAP);
    sat = cnt && (m.live == limit);
    if (cnt && !sat) n.live = m.live + 1;
    case (m.st)
      S_IDLE:  if (es) n.st = S_RUN;
      S_RUN: begin
        if (es) n.st = S_PAUSE;
        else if (el) begin n.st = S_LAP; n.snap = m.live; end
      end
      S_LAP: begin
        if (el) n.st = S_RUN;
        else if (es) n.st = S_PAUSE;
      end
      default: begin
        if (ec) begin n.st = S_IDLE; n.live = 0; n.snap = 0; n.ovf = 1'b0; end
        else if (es) n.st = S_RUN;
      end
    endcase
    if (sat) begin n.ovf = 1'b1; n.st = S_PAUSE; end
    n.ps = s; n.pl = l; n.pc = c;
    return n;
  endfunction

  function automatic exp_t disp(mdl_t m, bit auto_r);
    exp_t e;
    int src, mm, ss, cent;
    src  = (m.st == S_LAP) ? m.snap : m.live;
    mm   = src / 6000;
    ss   = (src / 100) % 60;
    cent = src % 100;
    if (auto_r && mm == 0) begin
      e.value = {4'(ss / 10), 4'(ss % 10), 4'(cent / 10), 4'(cent % 10)};
      e.dm = 1'b0;
    end else begin
      e.value = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
      e.dm = 1'b1;
    end
    e.run = (m.st == S_RUN) || (m.st == S_LAP);
    e.lap = (m.st == S_LAP);
    e.ovf = m.ovf;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  // Push expectations for the coming edge, drive inputs, advance models.
  task automatic apply(input bit s, input bit l, input bit c, input bit t);
    if (rst_n) begin
      qa.push_back(disp(ma, 1'b1));
      qb.push_back(disp(mb, 1'b0));
      ma = step(ma, 59, s, l, c, t);
      mb = step(mb, 0, s, l, c, t);
    end
    btn_start = s; btn_lap = l; btn_clear = c; tick = t;
    cs = s; cl = l; cc = c;
  endtask

  task automatic cycle(input bit s, input bit l, input bit c, input bit t);
    @(negedge clk);
    apply(s, l, c, t);
  endtask

  task automatic settle();
    cycle(cs, cl, cc, 1'b0);
    cycle(cs, cl, cc, 1'b0);
  endtask

  task automatic cmp(input string name, input exp_t e, input logic [15:0] v,
                     input logic dm, input logic run, input logic lap, input logic ovf);
    n_chk++;
    if (v !== e.value || dm !== e.dm || run !== e.run || lap !== e.lap || ovf !== e.ovf) begin
      n_fail++;
      $display("FAIL %s at %0t: got val=%h dm=%b run=%b lap=%b ovf=%b, expected val=%h dm=%b run=%b lap=%b ovf=%b",
               name, $time, v, dm, run, lap, ovf, e.value, e.dm, e.run, e.lap, e.ovf);
    end
  endtask

  // Monitor: outputs are presented every clock; compare against queued model output.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (qa.size() > 0) begin
          e = qa.pop_front();
          cmp("sb_a", e, value_a, dm_a, run_a, lap_a, ovf_a);
        end
        if (qb.size() > 0) begin
          e = qb.pop_front();
          cmp("sb_b", e, value_b, dm_b, run_b, lap_b, ovf_b);
        end
      end
    end
  end

  initial begin
    ma = mdl_reset();
    mb = mdl_reset();
    repeat (3) @(negedge clk);
    chk("reset_a", {12'h0, value_a, dm_a, run_a, lap_a, ovf_a}, 32'h0);
    chk("reset_b", {12'h0, value_b, dm_b, run_b, lap_b, ovf_b}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b0, 1'b0, 1'b0, 1'b0);

    // Start, 99 then 100 ticks.
    cycle(1, 0, 0, 0);
    repeat (99) cycle(1, 0, 0, 1);
    settle();
    chk("b_99ticks_mmss", {15'h0, value_b, dm_b}, {15'h0, 16'h0000, 1'b1});
    chk("a_99ticks", {15'h0, value_a, dm_a}, {15'h0, 16'h0099, 1'b0});
    cycle(1, 0, 0, 1);
    settle();
    chk("a_100ticks", {14'h0, value_a, dm_a, run_a}, {14'h0, 16'h0100, 1'b0, 1'b1});

    // To 6000 ticks: one minute on A, saturation on B.
    repeat (5900) cycle(1, 0, 0, 1);
    settle();
    chk("a_6000ticks", {15'h0, value_a, dm_a}, {15'h0, 16'h0100, 1'b1});
    chk("b_overflow", {14'h0, value_b, ovf_b, run_b}, {14'h0, 16'h0059, 1'b1, 1'b0});
    repeat (20) cycle(1, 0, 0, 1);
    settle();
    chk("b_hold", {16'h0, value_b}, {16'h0, 16'h0059});
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    settle();
    chk("b_clear", {15'h0, value_b, ovf_b}, 32'h0);
    chk("a_clear_ignored_run", {31'h0, run_a}, 32'h1);

    // A back to zero, then lap at 12.34.
    cycle(1, 0, 1, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (1234) cycle(1, 0, 0, 1);
    cycle(1, 1, 0, 0);
    repeat (50) cycle(1, 1, 0, 1);
    settle();
    chk("lap_freeze", {15'h0, value_a, lap_a}, {15'h0, 16'h1234, 1'b1});
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    settle();
    chk("lap_release", {15'h0, value_a, lap_a}, {15'h0, 16'h1284, 1'b0});

    // PAUSE: clear beats start; RUN: clear ignored.
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 1, 0);
    settle();
    chk("pause_clear_wins", {15'h0, value_a, run_a}, 32'h0);
    cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (10) cycle(1, 0, 0, 1);
    repeat (6) cycle(1, 0, 1, 1);
    settle();
    chk("run_clear_ignored", {15'h0, value_a, run_a}, {15'h0, 16'h0016, 1'b1});

    // Async reset mid-LAP with tick active.
    cycle(1, 1, 0, 1);
    repeat (5) cycle(1, 1, 0, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_a", {12'h0, value_a, dm_a, run_a, lap_a, ovf_a}, 32'h0);
    chk("async_reset_b", {12'h0, value_b, dm_b, run_b, lap_b, ovf_b}, 32'h0);
    repeat (3) cycle(0, 1, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;
    ma = mdl_reset();
    mb = mdl_reset();
    apply(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (3) cycle(0, 0, 0, 1);
    settle();
    chk("post_reset_no_count", {15'h0, value_a, run_a}, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(cs ^ ($urandom_range(0, 7) == 0), cl ^ ($urandom_range(0, 7) == 0),
            cc ^ ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
    end
    settle();
    repeat (3) @(posedge clk);
    #2;
    chk("queues_drained", qa.size() + qb.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
